// File: rtl/fir_serial_mac_dbuf_if.sv
// Sample handshake and coefficient-write bundle for fir_serial_mac_dbuf.
// master = sample source / host side, slave = filter side.
interface fir_serial_mac_dbuf_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 64,
    parameter int OUT_W  = 16
);
    localparam int AW = $clog2(TAPS);

    logic                     i_valid;
    logic                     o_ready;
    logic signed [DATA_W-1:0] i_signal_sample;
    logic                     i_write_enable;
    logic [AW-1:0]            i_write_address;
    logic signed [COEF_W-1:0] i_coeffs_in;
    logic                     i_write_done;
    logic                     o_swap_pending;
    logic                     o_bank_sel;
    logic signed [OUT_W-1:0]  o_sample;
    logic                     o_valid;

    modport master (
        output i_valid, i_signal_sample, i_write_enable, i_write_address,
               i_coeffs_in, i_write_done,
        input  o_ready, o_swap_pending, o_bank_sel, o_sample, o_valid
    );

    modport slave (
        input  i_valid, i_signal_sample, i_write_enable, i_write_address,
               i_coeffs_in, i_write_done,
        output o_ready, o_swap_pending, o_bank_sel, o_sample, o_valid
    );
endinterface

// File: rtl/fir_serial_mac_dbuf.sv
// Serial single-MAC TAPS-tap FIR with double-buffered coefficients.
// Define FIR_SATURATE_EN to clamp the output instead of wrapping it.
module fir_serial_mac_dbuf #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 64,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_enable,
    fir_serial_mac_dbuf_if.slave bus
);
    localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
    localparam int PW    = DATA_W + COEF_W;
    localparam int AW    = $clog2(TAPS);

`ifdef FIR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] x_q [TAPS];
    logic signed [DATA_W-1:0] x_d [TAPS];
    logic signed [COEF_W-1:0] h_q [2][TAPS];
    logic signed [COEF_W-1:0] h_d [2][TAPS];
    logic                     bank_sel_q, bank_sel_d;
    logic                     swap_pending_q, swap_pending_d;
    logic signed [OUT_W-1:0]  sample_q, sample_d;

    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc_sum;
`ifdef FIR_SATURATE_EN
    logic signed [ACC_W-1:0]  acc_shr;
`endif

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        acc_d          = acc_q;
        x_d            = x_q;
        h_d            = h_q;
        bank_sel_d     = bank_sel_q;
        swap_pending_d = swap_pending_q;
        sample_d       = sample_q;

        // Operands are widened first so the product is full precision.
        prod    = PW'(x_q[k_q]) * PW'(h_q[bank_sel_q][k_q]);
        acc_sum = acc_q + ACC_W'(prod);
`ifdef FIR_SATURATE_EN
        acc_shr = acc_sum >>> OUT_SHIFT;
`endif

        if (clk_enable) begin
            // Shadow is chosen from the pre-swap bank, so a write coinciding
            // with a swap lands in the bank that becomes active.
            if (bus.i_write_enable && (int'(bus.i_write_address) < TAPS))
                h_d[~bank_sel_q][bus.i_write_address] = bus.i_coeffs_in;
            swap_pending_d = swap_pending_q | bus.i_write_done;

            unique case (state_q)
                IDLE: begin
                    if (swap_pending_q) begin
                        bank_sel_d     = ~bank_sel_q;
                        swap_pending_d = 1'b0;
                    end
                    if (bus.i_valid) begin
                        x_d[0] = bus.i_signal_sample;
                        for (int i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
                        acc_d   = '0;
                        k_d     = '0;
                        state_d = MAC;
                    end
                end
                MAC: begin
                    acc_d = acc_sum;
                    k_d   = k_q + AW'(1);
                    if (k_q == AW'(TAPS - 1)) begin
                        k_d     = '0;
                        state_d = OUT;
`ifdef FIR_SATURATE_EN
                        if (acc_shr > SAT_MAX)      sample_d = SAT_MAX[OUT_W-1:0];
                        else if (acc_shr < SAT_MIN) sample_d = SAT_MIN[OUT_W-1:0];
                        else                        sample_d = acc_shr[OUT_W-1:0];
`else
                        sample_d = OUT_W'(acc_sum >>> OUT_SHIFT);
`endif
                    end
                end
                OUT:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            k_q            <= '0;
            acc_q          <= '0;
            bank_sel_q     <= 1'b0;
            swap_pending_q <= 1'b0;
            sample_q       <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i]    <= '0;
                h_q[0][i] <= '0;
                h_q[1][i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            acc_q          <= acc_d;
            bank_sel_q     <= bank_sel_d;
            swap_pending_q <= swap_pending_d;
            sample_q       <= sample_d;
            x_q            <= x_d;
            h_q            <= h_d;
        end
    end

    assign bus.o_ready        = (state_q == IDLE);
    assign bus.o_valid        = (state_q == OUT);
    assign bus.o_sample       = sample_q;
    assign bus.o_bank_sel     = bank_sel_q;
    assign bus.o_swap_pending = swap_pending_q;
endmodule

// File: doc/fir_serial_mac_dbuf.md
Name: fir_serial_mac_dbuf

Overview:
Parametrised successor to the fixed 64-tap serial FIR datapath: one time-multiplexed MAC computes a TAPS-tap FIR per input sample.
- Input is a valid/ready handshake instead of a fixed phase_63 strobe.
- Coefficients are double-buffered: host writes go to a shadow bank, which swaps in atomically at a sample boundary after write_done.
- Sits between the audio sample source and the band-gain/summing stage; one instance per equalizer band.

Parameters:
DATA_W, 16, signed input sample width
COEF_W, 16, signed coefficient width
TAPS, 64, number of taps, 2..256
OUT_W, 16, signed output width
OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before output
ACC_W, DATA_W+COEF_W+$clog2(TAPS), accumulator width (derived, localparam)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
clk_enable  in  1  global enable; when low all state holds
i_valid  in  1  input sample valid
o_ready  out  1  block can accept a sample (high only in IDLE)
i_signal_sample  in  DATA_W  signed input sample
i_write_enable  in  1  coefficient write strobe
i_write_address  in  $clog2(TAPS)  tap index to write
i_coeffs_in  in  COEF_W  signed coefficient value
i_write_done  in  1  pulse: shadow bank complete, request swap
o_swap_pending  out  1  swap requested, not yet applied
o_bank_sel  out  1  index of the active coefficient bank
o_sample  out  OUT_W  signed filtered output
o_valid  out  1  o_sample valid, one enabled cycle

Behaviour:
- Reset (rst=0, async): state=IDLE; delay line, both coefficient banks and accumulator cleared to 0; o_bank_sel=0, o_swap_pending=0, o_valid=0, o_sample=0, o_ready=1.
- clk_enable=0: no register changes (FSM, delay line, banks, flags, outputs all hold); writes and handshakes are ignored.
- FSM states:
  - IDLE: o_ready=1. Accept on i_valid & clk_enable; shift the delay line (x[0]<=sample, x[k]<=x[k-1], x[TAPS-1] discarded); clear acc; go to MAC.
  - MAC: TAPS enabled cycles, k=0..TAPS-1; acc += x[k]*h_active[k]; after k=TAPS-1 go to OUT.
  - OUT: load o_sample; o_valid=1 for exactly this enabled cycle; go to IDLE.
- Latency: accept in enabled cycle N, o_valid in enabled cycle N+TAPS+1. Throughput is one sample per TAPS+2 enabled cycles.
- Arithmetic:
  - Products are full-precision signed DATA_W+COEF_W, sign-extended into ACC_W; no overflow inside acc by construction.
  - Output = acc >>> OUT_SHIFT (arithmetic shift, truncation toward -inf), then reduced to OUT_W per the Optional Feature.
- Coefficient writes:
  - i_write_enable in an enabled cycle writes i_coeffs_in to shadow bank entry i_write_address, in any FSM state.
  - "Shadow" is defined as !o_bank_sel at the start of that cycle.
  - Addresses >= TAPS are ignored.
- Swap:
  - i_write_done (enabled cycle) sets o_swap_pending.
  - In any enabled IDLE cycle with o_swap_pending=1: o_bank_sel toggles and o_swap_pending clears.
  - If a sample is accepted in that same cycle, its MAC uses the new bank.
  - A swap never occurs in MAC or OUT, so every output uses one bank only.
  - i_write_done while already pending has no extra effect (no double toggle).
  - After a swap the new shadow holds the previous active coefficients; partial rewrites are allowed.
- Simultaneous i_write_enable and swap in the same cycle: the write lands in the pre-swap shadow, which becomes active that cycle.
- Reset asserted mid-MAC: the in-flight result is discarded and o_valid is not produced.

Optional Feature:
Macro FIR_SATURATE_EN.
- Defined: the shifted value is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: the low OUT_W bits are taken (two's-complement wrap).

Test Plan:
1. Impulse: write h[k]=k+1 into the shadow bank, pulse write_done, then feed 32767 followed by zeros (OUT_SHIFT=15) -> outputs 0,1,2,...,63 (32767*(k+1)>>>15 = k); each o_valid exactly 65 enabled cycles after its accept; o_bank_sel=1.
2. Swap timing: pulse write_done during MAC -> o_swap_pending=1 until the next IDLE cycle; the current output still uses the old bank and the next sample uses the new one.
3. Saturation: all h=32767, all x=32767 -> with FIR_SATURATE_EN o_sample=32767; without it, o_sample = low 16 bits of (64*32767*32767)>>>15.
4. Backpressure and stall: hold i_valid high continuously -> accepts exactly one sample per 66 enabled cycles. Drop clk_enable for 10 cycles mid-MAC -> result unchanged, latency extended by 10 cycles.
5. Reset mid-MAC: assert rst at k=20 -> o_valid stays 0, all outputs return to reset values, o_ready=1 immediately.
6. Address bound: TAPS=48, write address 50 -> no bank change; impulse response unaffected.
